// File: rtl/game_pkg.sv
// Shared types, constants and helpers for the match sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        MENU,
        READY,
        COUNTDOWN,
        PLAY,
        PAUSED,
        GAME_OVER
    } seq_state_t;

    localparam logic PLAYER_1    = 1'b0;
    localparam logic PLAYER_2    = 1'b1;
    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_MULTI  = 1'b1;

    // Screen/status lines that follow directly from the state and mode flag
    typedef struct packed {
        logic idle;
        logic single;
        logic multi;
        logic paused;
        logic over;
    } screen_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Status lines shown while sitting in state s with mode flag m
    function automatic screen_t screen_decode(input seq_state_t s, input logic m);
        screen_t v;
        v        = '0;
        v.idle   = (s == MENU);
        v.single = (s != MENU) && (m == MODE_SINGLE);
        v.multi  = (s != MENU) && (m == MODE_MULTI);
        v.paused = (s == PAUSED);
        v.over   = (s == GAME_OVER);
        return v;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a debounced button level.
module edge_detect (
    input  logic clk65MHz,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic r_prev;

    // Remember last cycle's level
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= in;
        end
    end

    assign rise = in & ~r_prev;

endmodule

// File: rtl/match_sequencer.sv
// Game scheduler: menu, serve ownership, countdown, pause and game-over.
module match_sequencer
    import game_pkg::*;
#(
    parameter int unsigned WIN_POINTS        = 15,
    parameter int unsigned FRAMES_PER_DIGIT  = 60,
    parameter int unsigned AUTO_SERVE_FRAMES = 300
) (
    input  logic       clk65MHz,
    input  logic       rst,
    input  logic       end_of_frame,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_serve_p1,
    input  logic       btn_serve_p2,
    input  logic       btn_pause,
    input  logic [3:0] points_player_1,
    input  logic [3:0] points_player_2,
    output logic       screen_idle,
    output logic       screen_single,
    output logic       screen_multi,
    output logic       serve,
    output logic       frame_tick,
    output logic       server,
    output logic [1:0] countdown_digit,
    output logic       paused,
    output logic       game_over,
    output logic       winner
);

    localparam int unsigned CNT_MAX = max_u(FRAMES_PER_DIGIT, AUTO_SERVE_FRAMES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PTS_W   = 4;

    logic w_rise_start;
    logic w_rise_mode;
    logic w_rise_s1;
    logic w_rise_s2;
    logic w_rise_pause;

    edge_detect u_ed_start (.clk65MHz(clk65MHz), .rst(rst), .in(btn_start),    .rise(w_rise_start));
    edge_detect u_ed_mode  (.clk65MHz(clk65MHz), .rst(rst), .in(btn_mode),     .rise(w_rise_mode));
    edge_detect u_ed_s1    (.clk65MHz(clk65MHz), .rst(rst), .in(btn_serve_p1), .rise(w_rise_s1));
    edge_detect u_ed_s2    (.clk65MHz(clk65MHz), .rst(rst), .in(btn_serve_p2), .rise(w_rise_s2));
    edge_detect u_ed_pause (.clk65MHz(clk65MHz), .rst(rst), .in(btn_pause),    .rise(w_rise_pause));

    seq_state_t        r_state;
    seq_state_t        r_ret;
    logic              r_mode;
    logic              r_server;
    logic              r_winner;
    logic [1:0]        r_digit;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_serve;
    logic              r_pend;
    logic              r_pend_who;
    logic              r_pend_win;
    screen_t           r_scr;
    logic [PTS_W-1:0]  r_p1_prev;
    logic [PTS_W-1:0]  r_p2_prev;

    logic w_p1_pt;
    logic w_p2_pt;
    logic w_score;
    logic w_scorer;
    logic w_win;
    logic w_serve_ok;
    logic w_mode_next;
    logic w_pause_entry;
    logic w_apply;
    logic w_apply_who;
    logic w_apply_win;

    // A point is exactly a +1 step; widened so 15 -> 0 is not mistaken for one
    assign w_p1_pt  = ({1'b0, points_player_1} == ({1'b0, r_p1_prev} + 5'd1));
    assign w_p2_pt  = ({1'b0, points_player_2} == ({1'b0, r_p2_prev} + 5'd1));
    assign w_score  = w_p1_pt | w_p2_pt;
    assign w_scorer = w_p1_pt ? PLAYER_1 : PLAYER_2;
    assign w_win    = w_p1_pt ? (points_player_1 == PTS_W'(WIN_POINTS))
                              : (points_player_2 == PTS_W'(WIN_POINTS));

    assign frame_tick = end_of_frame & (r_state != PAUSED);

    // Single mode always serves from player 1's button
    assign w_serve_ok = (r_mode == MODE_SINGLE || r_server == PLAYER_1) ? w_rise_s1 : w_rise_s2;

    assign w_mode_next   = (r_state == MENU && w_rise_mode) ? ~r_mode : r_mode;
    assign w_pause_entry = w_rise_pause &&
                           (r_state == READY || r_state == COUNTDOWN || r_state == PLAY);

    // A point acts immediately in PLAY, or at resume for anything collected while paused
    assign w_apply     = (r_state == PLAY && w_score && !w_rise_pause) ||
                         (r_state == PAUSED && w_rise_pause && (w_score || r_pend));
    assign w_apply_who = w_score ? w_scorer : r_pend_who;
    assign w_apply_win = w_score ? w_win : r_pend_win;

    // Registered copies of the point counters
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_p1_prev <= '0;
            r_p2_prev <= '0;
        end else begin
            r_p1_prev <= points_player_1;
            r_p2_prev <= points_player_2;
        end
    end

    // Match state machine with registered outputs
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_state    <= MENU;
            r_ret      <= MENU;
            r_mode     <= MODE_SINGLE;
            r_server   <= PLAYER_1;
            r_winner   <= PLAYER_1;
            r_digit    <= '0;
            r_cnt      <= '0;
            r_serve    <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_who <= PLAYER_1;
            r_pend_win <= 1'b0;
            r_scr      <= screen_decode(MENU, MODE_SINGLE);
        end else begin
            r_serve <= 1'b0;
            if (w_pause_entry) begin
                r_state <= PAUSED;
                r_ret   <= r_state;
                r_scr   <= screen_decode(PAUSED, r_mode);
                if (r_state == PLAY && w_score) begin
                    r_pend     <= 1'b1;
                    r_pend_who <= w_scorer;
                    r_pend_win <= w_win;
                end
            end else if (w_apply) begin
                r_server <= ~w_apply_who;
                r_pend   <= 1'b0;
                r_digit  <= '0;
                r_cnt    <= '0;
                if (w_apply_win) begin
                    r_state  <= GAME_OVER;
                    r_winner <= w_apply_who;
                    r_scr    <= screen_decode(GAME_OVER, r_mode);
                end else begin
                    r_state <= READY;
                    r_scr   <= screen_decode(READY, r_mode);
                end
            end else begin
                case (r_state)
                    MENU: begin
                        r_mode <= w_mode_next;
                        if (w_rise_start) begin
                            r_state  <= READY;
                            r_server <= PLAYER_1;
                            r_cnt    <= '0;
                            r_scr    <= screen_decode(READY, w_mode_next);
                        end
                    end
                    READY: begin
                        if (w_serve_ok ||
                            (frame_tick && r_cnt == CNT_W'(AUTO_SERVE_FRAMES - 1))) begin
                            r_state <= COUNTDOWN;
                            r_cnt   <= '0;
                            r_digit <= 2'd3;
                            r_scr   <= screen_decode(COUNTDOWN, r_mode);
                        end else if (frame_tick) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    COUNTDOWN: begin
                        if (frame_tick) begin
                            if (r_cnt == CNT_W'(FRAMES_PER_DIGIT - 1)) begin
                                r_cnt <= '0;
                                if (r_digit == 2'd1) begin
                                    r_state <= PLAY;
                                    r_digit <= '0;
                                    r_serve <= 1'b1;
                                    r_scr   <= screen_decode(PLAY, r_mode);
                                end else begin
                                    r_digit <= r_digit - 2'd1;
                                end
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    PLAY: begin
                        r_state <= PLAY;
                    end
                    PAUSED: begin
                        if (w_rise_pause) begin
                            r_state <= r_ret;
                            r_scr   <= screen_decode(r_ret, r_mode);
                        end else if (w_score) begin
                            r_pend     <= 1'b1;
                            r_pend_who <= w_scorer;
                            r_pend_win <= w_win;
                        end
                    end
                    GAME_OVER: begin
                        if (w_rise_start) begin
                            r_state  <= MENU;
                            r_winner <= PLAYER_1;
                            r_scr    <= screen_decode(MENU, r_mode);
                        end
                    end
                    default: begin
                        r_state <= MENU;
                        r_scr   <= screen_decode(MENU, r_mode);
                    end
                endcase
            end
        end
    end

    assign screen_idle     = r_scr.idle;
    assign screen_single   = r_scr.single;
    assign screen_multi    = r_scr.multi;
    assign paused          = r_scr.paused;
    assign game_over       = r_scr.over;
    assign serve           = r_serve;
    assign server          = r_server;
    assign winner          = r_winner;
    assign countdown_digit = r_digit;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer against a game-rule reference model.
`timescale 1ns/1ps
module tb_match_sequencer;

    localparam int WIN  = 3;
    localparam int FPD  = 2;
    localparam int AUTO = 5;

    localparam int B_START = 0;
    localparam int B_MODE  = 1;
    localparam int B_S1    = 2;
    localparam int B_S2    = 3;
    localparam int B_PAUSE = 4;

    logic       clk65MHz = 1'b0;
    logic       rst, end_of_frame, btn_start, btn_mode, btn_serve_p1, btn_serve_p2, btn_pause;
    logic [3:0] points_player_1, points_player_2;
    logic       screen_idle, screen_single, screen_multi, serve, frame_tick;
    logic       server, paused, game_over, winner;
    logic [1:0] countdown_digit;

    always #5 clk65MHz = ~clk65MHz;

    match_sequencer #(
        .WIN_POINTS(WIN), .FRAMES_PER_DIGIT(FPD), .AUTO_SERVE_FRAMES(AUTO)
    ) dut (
        .clk65MHz(clk65MHz), .rst(rst), .end_of_frame(end_of_frame),
        .btn_start(btn_start), .btn_mode(btn_mode), .btn_serve_p1(btn_serve_p1),
        .btn_serve_p2(btn_serve_p2), .btn_pause(btn_pause),
        .points_player_1(points_player_1), .points_player_2(points_player_2),
        .screen_idle(screen_idle), .screen_single(screen_single), .screen_multi(screen_multi),
        .serve(serve), .frame_tick(frame_tick), .server(server),
        .countdown_digit(countdown_digit), .paused(paused), .game_over(game_over),
        .winner(winner)
    );

    typedef enum int {P_MENU, P_READY, P_CD, P_PLAY, P_PAUSED, P_OVER} phase_t;
    typedef struct {
        bit         serve;
        logic [8:0] tup;
        int         efc;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         efc = 0;
    bit         mon_en = 1'b0;
    logic [8:0] mon_last;

    // Reference model state: game rules expressed as frames remaining
    phase_t     ph, ret_ph;
    bit         m_mode, m_server, m_win_who, m_pend, m_pend_who, m_pend_win;
    int         ready_left, cd_left, pprev1, pprev2;
    logic [4:0] bprev;
    logic [8:0] m_last;
    logic [3:0] cur_p1 = 4'd0;
    logic [3:0] cur_p2 = 4'd0;

    // Observable tuple {idle,single,multi,paused,over,winner,digit,server}
    function automatic logic [8:0] m_tuple();
        bit menu;
        int d;
        menu = (ph == P_MENU);
        d    = 0;
        if (ph == P_CD || (ph == P_PAUSED && ret_ph == P_CD))
            d = (cd_left + FPD - 1) / FPD;
        return {menu, !menu && !m_mode, !menu && m_mode, ph == P_PAUSED, ph == P_OVER,
                (ph == P_OVER) ? m_win_who : 1'b0, 2'(d), m_server};
    endfunction

    function automatic void model_reset();
        ph = P_MENU; ret_ph = P_MENU;
        m_mode = 0; m_server = 0; m_win_who = 0;
        m_pend = 0; m_pend_who = 0; m_pend_win = 0;
        ready_left = 0; cd_left = 0; pprev1 = 0; pprev2 = 0;
        bprev = '0;
    endfunction

    // Scorer's opponent serves next; a winning value ends the match
    function automatic void m_score(input bit who, input bit win);
        m_server = !who;
        m_pend   = 0;
        if (win) begin
            ph = P_OVER;
            m_win_who = who;
        end else begin
            ph = P_READY;
            ready_left = AUTO;
        end
    endfunction

    function automatic void m_pause();
        ret_ph = ph;
        ph     = P_PAUSED;
    endfunction

    function automatic bit model_step(input bit r, input bit f, input logic [4:0] b,
                                      input int q1, input int q2);
        logic [4:0] e;
        bit pt1, pt2, pt, who, win, tick, ok, srv;
        srv = 0;
        if (r) begin
            model_reset();
            return 0;
        end
        e = b & ~bprev;
        bprev = b;
        pt1 = (q1 == pprev1 + 1);
        pt2 = (q2 == pprev2 + 1);
        pprev1 = q1;
        pprev2 = q2;
        pt   = pt1 || pt2;
        who  = pt1 ? 1'b0 : 1'b1;
        win  = pt1 ? (q1 == WIN) : (q2 == WIN);
        tick = f && (ph != P_PAUSED);
        case (ph)
            P_MENU: begin
                if (e[B_MODE]) m_mode = !m_mode;
                if (e[B_START]) begin
                    ph = P_READY; m_server = 0; ready_left = AUTO;
                end
            end
            P_READY: begin
                if (e[B_PAUSE]) m_pause();
                else begin
                    ok = (!m_mode || !m_server) ? e[B_S1] : e[B_S2];
                    if (tick) ready_left--;
                    if (ok || ready_left == 0) begin
                        ph = P_CD; cd_left = 3 * FPD;
                    end
                end
            end
            P_CD: begin
                if (e[B_PAUSE]) m_pause();
                else if (tick) begin
                    cd_left--;
                    if (cd_left == 0) begin
                        ph = P_PLAY; srv = 1;
                    end
                end
            end
            P_PLAY: begin
                if (e[B_PAUSE]) begin
                    if (pt) begin
                        m_pend = 1; m_pend_who = who; m_pend_win = win;
                    end
                    m_pause();
                end else if (pt) m_score(who, win);
            end
            P_PAUSED: begin
                if (pt) begin
                    m_pend = 1; m_pend_who = who; m_pend_win = win;
                end
                if (e[B_PAUSE]) begin
                    if (m_pend) m_score(m_pend_who, m_pend_win);
                    else ph = ret_ph;
                end
            end
            P_OVER: begin
                if (e[B_START]) ph = P_MENU;
            end
            default: ph = P_MENU;
        endcase
        return srv;
    endfunction

    // Drive one cycle of inputs, advance the model, queue any expected output event
    task automatic cyc(input bit r, input bit f, input logic [4:0] b);
        bit         srv, exp_ft;
        logic [8:0] t;
        ev_t        ev;
        @(negedge clk65MHz);
        rst = r;
        end_of_frame = f;
        {btn_pause, btn_serve_p2, btn_serve_p1, btn_mode, btn_start} = b;
        points_player_1 = cur_p1;
        points_player_2 = cur_p2;
        if (f) efc++;
        exp_ft = f && !r && (ph != P_PAUSED);
        srv = model_step(r, f, b, int'(cur_p1), int'(cur_p2));
        t = m_tuple();
        if (srv || t != m_last) begin
            ev.serve = srv; ev.tup = t; ev.efc = efc;
            exp_q.push_back(ev);
        end
        m_last = t;
        if (!r) begin
            #1;
            checks++;
            if (frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL frame_tick: got %b expected %b at efc=%0d", frame_tick, exp_ft, efc);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 5'd0);
    endtask

    task automatic press(input int btn);
        logic [4:0] b;
        b = '0;
        b[btn] = 1'b1;
        cyc(0, 0, b);
        cyc(0, 0, 5'd0);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(0, 1, 5'd0);
            cyc(0, 0, 5'd0);
        end
    endtask

    task automatic rally();
        press((!m_mode || !m_server) ? B_S1 : B_S2);
        frames(3 * FPD);
    endtask

    // Monitor: every serve pulse or status change must match the next queued event
    initial begin : monitor
        logic [8:0] cur;
        ev_t        ev;
        forever begin
            @(posedge clk65MHz);
            #1;
            if (mon_en) begin
                cur = {screen_idle, screen_single, screen_multi, paused, game_over,
                       winner, countdown_digit, server};
                if (serve === 1'b1 || cur !== mon_last) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL event: unexpected serve=%b status=%b at efc=%0d, none required",
                                 serve, cur, efc);
                    end else begin
                        ev = exp_q.pop_front();
                        if (ev.serve !== serve || ev.tup !== cur || ev.efc != efc) begin
                            errors++;
                            $display("FAIL event: got serve=%b status=%b efc=%0d, required serve=%b status=%b efc=%0d",
                                     serve, cur, efc, ev.serve, ev.tup, ev.efc);
                        end
                    end
                    mon_last = cur;
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; end_of_frame = 1'b0;
        btn_start = 1'b0; btn_mode = 1'b0; btn_serve_p1 = 1'b0; btn_serve_p2 = 1'b0; btn_pause = 1'b0;
        points_player_1 = 4'd0; points_player_2 = 4'd0;
        model_reset();
        m_last = m_tuple();
        repeat (3) cyc(1, 0, 5'd0);
        @(posedge clk65MHz);
        #1;
        checks++;
        if ({screen_idle, screen_single, screen_multi, paused, game_over, winner,
             countdown_digit, server, serve} !== {m_last, 1'b0}) begin
            errors++;
            $display("FAIL reset: got %b required %b",
                     {screen_idle, screen_single, screen_multi, paused, game_over, winner,
                      countdown_digit, server, serve}, {m_last, 1'b0});
        end
        mon_last = m_last;
        mon_en   = 1'b1;

        // Menu: select multi and start
        press(B_MODE);
        press(B_START);
        // Non-server press ignored, then served countdown
        press(B_S2);
        idle(2);
        press(B_S1);
        frames(3 * FPD);
        // Player 1 scores, then a clear is silent
        cur_p1 = 4'd1;
        idle(2);
        cur_p1 = 4'd0;
        idle(2);
        // Auto serve after the timeout
        frames(AUTO + 3 * FPD);
        // Point to get back to READY, then pause mid-countdown
        cur_p1 = 4'd1;
        idle(2);
        press((!m_mode || !m_server) ? B_S1 : B_S2);
        frames(FPD);
        press(B_PAUSE);
        frames(10);
        press(B_PAUSE);
        frames(2 * FPD);
        // Player 2 runs to the winning score
        for (int k = 1; k <= WIN; k++) begin
            cur_p2 = 4'(k);
            idle(2);
            if (k < WIN) rally();
        end
        press(B_S1);
        press(B_START);
        cur_p1 = 4'd0;
        cur_p2 = 4'd0;
        idle(2);
        // Held mode level toggles once; single mode ignores player 2's serve
        repeat (3) cyc(0, 0, 5'b00010);
        idle(1);
        press(B_START);
        press(B_PAUSE);
        frames(2);
        press(B_PAUSE);
        press(B_S2);
        press(B_S1);
        frames(3 * FPD);
        // Reset mid-match
        cyc(1, 0, 5'd0);
        idle(2);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            bit         r, f;
            logic [4:0] b;
            int         idx;
            b = '0;
            r = ($urandom_range(0, 999) < 2);
            f = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 12) begin
                idx = int'($urandom_range(0, 4));
                b[idx] = 1'b1;
            end
            if ($urandom_range(0, 99) < 6) begin
                if ($urandom_range(0, 1) == 0)
                    cur_p1 = ($urandom_range(0, 9) < 8 && cur_p1 < 4'd15) ? 4'(cur_p1 + 4'd1) : 4'd0;
                else
                    cur_p2 = ($urandom_range(0, 9) < 8 && cur_p2 < 4'd15) ? 4'(cur_p2 + 4'd1) : 4'd0;
            end
            cyc(r, f, b);
        end
        idle(6);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d events still outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
Top-level game scheduler that sequences the ball datapath. It owns the menu (single/multi selection), serve ownership, a pre-serve countdown, pause, and game-over. It drives the screen_idle/screen_single/screen_multi mode lines, a one-cycle serve pulse, and a pause-gated frame tick into ball_control. It watches the point counters coming back from ball_control to detect each scored point.

Parameters:
WIN_POINTS, 15, score that ends the match (compare with ==).
FRAMES_PER_DIGIT, 60, frames shown per countdown digit.
AUTO_SERVE_FRAMES, 300, frames in READY before the serve happens without a button press.

Ports:
clk65MHz  in  1  system clock
rst  in  1  reset
end_of_frame  in  1  one-cycle pulse per video frame
btn_start  in  1  debounced level
btn_mode  in  1  debounced level; toggles single/multi in menu
btn_serve_p1  in  1  debounced level
btn_serve_p2  in  1  debounced level
btn_pause  in  1  debounced level
points_player_1  in  4  from ball_control
points_player_2  in  4  from ball_control
screen_idle  out  1  menu/attract mode
screen_single  out  1  single-player match active
screen_multi  out  1  multi-player match active
serve  out  1  one-cycle serve pulse to ball_control
frame_tick  out  1  end_of_frame gated by pause
server  out  1  0 = player 1 serves, 1 = player 2 serves
countdown_digit  out  2  3/2/1 during countdown, 0 otherwise
paused  out  1  high in PAUSED
game_over  out  1  high in GAME_OVER
winner  out  1  0 = player 1, 1 = player 2; valid while game_over

Behaviour:
- Clock and reset: single clock clk65MHz; reset rst is synchronous, active-high.
- Reset values:
  - state = MENU, screen_idle = 1, all other outputs 0.
  - mode flag = single, all counters 0.
- Buttons: each button is rising-edge detected internally. Only the 1-cycle edge pulse is used. A held level never repeats.
- States and transitions:
  - MENU: btn_mode edge toggles the mode flag. btn_start edge goes to READY with server = 0.
  - READY:
    - Exit on a serve edge from the current server, or on AUTO_SERVE_FRAMES end_of_frame pulses. Either exit goes to COUNTDOWN.
    - In single mode only btn_serve_p1 counts, whatever the server value.
    - An edge from the non-server player is ignored.
  - COUNTDOWN:
    - countdown_digit starts at 3 and decrements every FRAMES_PER_DIGIT frame_ticks.
    - After digit 1 expires, go to PLAY.
    - serve = 1 for exactly the first cycle in PLAY, registered.
  - PLAY: score detection is described in its own bullet below. On a non-winning point, go to READY.
  - PAUSED:
    - Entered from READY, COUNTDOWN or PLAY on a btn_pause edge. The return state is saved.
    - A second btn_pause edge returns to the saved state.
    - All frame counters hold.
  - GAME_OVER: game_over = 1 and winner is latched. A btn_start edge goes to MENU.
- Score detection:
  - Registered copies of both point inputs are kept.
  - A point is scored only when a counter equals its previous value + 1.
  - Any other change, such as a clear to 0 in IDLE/WIN, updates the copies silently.
  - Player 1 scores: server := 1. Player 2 scores: server := 0. The conceding player serves next.
  - If the new value == WIN_POINTS, go to GAME_OVER with winner = scorer. Otherwise go to READY.
  - Points are tracked in every state. A point only causes a transition in PLAY or PAUSED. A point while PAUSED is applied on resume.
- Mode lines:
  - screen_idle = 1 in MENU only.
  - screen_single / screen_multi follow the mode flag in all other states. They are mutually exclusive and registered.
- frame_tick = end_of_frame when state != PAUSED, else 0. Combinational, zero latency.
- Counter rules:
  - Counters advance only on frame_tick. They are cleared on entry to READY and COUNTDOWN.
  - Width is $clog2(max param + 1). No wrap is possible because the state exits at the terminal count.
- Simultaneous events, in priority order:
  1. rst
  2. pause edge
  3. score
  4. serve / timeout
  5. btn_start
- btn_start has no effect outside MENU and GAME_OVER.
- Reset mid-match returns to MENU immediately. serve never fires in the reset cycle.

Decomposition:
- Package game_pkg holds:
  - typedef enum seq_state_t {MENU, READY, COUNTDOWN, PLAY, PAUSED, GAME_OVER};
  - constants PLAYER_1 = 0, PLAYER_2 = 1, MODE_SINGLE = 0, MODE_MULTI = 1.
- One sub-module: edge_detect (clk65MHz, rst, in, rise). Instantiated five times, once per button.

Test Plan:
Use WIN_POINTS=3, FRAMES_PER_DIGIT=2, AUTO_SERVE_FRAMES=5 throughout.
1. Reset, then btn_mode edge, then btn_start edge -> screen_multi=1, screen_idle=0, state READY, server=0.
2. In READY (multi), btn_serve_p2 edge -> ignored. Then btn_serve_p1 edge -> countdown_digit 3,3,2,2,1,1 across 6 frame ticks, then serve high exactly 1 cycle.
3. In READY, no press -> after the 5th end_of_frame, enter COUNTDOWN. Total serve delay is 5+6 frames.
4. In PLAY, points_player_1 0->1 -> server=1, state READY. Then points_player_1 1->0 (clear) -> no transition.
5. btn_pause edge at countdown_digit=2 -> paused=1, frame_tick=0 for 10 frames, digit stays 2. Second edge -> resumes with the same remaining count.
6. points_player_2 steps 2->3 in PLAY -> game_over=1, winner=1. A serve edge is ignored; btn_start edge -> screen_idle=1.
